// File: rtl/rocket_trace_pkg.sv
// Shared types and constants for the Rocket retire trace buffer.
// trace_entry_t is the default-width view of one buffered commit event.
package rocket_trace_pkg;

    localparam int DEF_PC_W   = 40;
    localparam int DEF_INSN_W = 32;
    localparam int DEF_SEQ_W  = 32;
    localparam int DEF_DROP_W = 16;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_S = 2'd1;
    localparam logic [1:0] PRIV_M = 2'd3;

    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_INSN_W-1:0] insn;
        logic [1:0]            priv;
        logic [DEF_SEQ_W-1:0]  seq;
        logic [DEF_DROP_W-1:0] drops;
    } trace_entry_t;

endpackage

// File: rtl/rocket_trace_fifo.sv
// Generic synchronous FIFO; full/empty are derived from the registered count,
// so a push at full or a pop at empty is ignored regardless of the other side.
module rocket_trace_fifo
    import rocket_trace_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = logic [7:0]
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  T                         wr_data,
    output T                         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; validity is tracked by count.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/rocket_retire_trace_buf.sv
// Retire trace buffer: tags each captured commit with a sequence number and
// the count of drops preceding it, and queues it for a valid/ready consumer.
module rocket_retire_trace_buf
    import rocket_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PC_W   = DEF_PC_W,
    parameter int INSN_W = DEF_INSN_W,
    parameter int SEQ_W  = DEF_SEQ_W,
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     flush,
    input  logic                     retire_valid,
    input  logic [PC_W-1:0]          retire_pc,
    input  logic [INSN_W-1:0]        retire_insn,
    input  logic [1:0]               retire_priv,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [PC_W-1:0]          trace_pc,
    output logic [INSN_W-1:0]        trace_insn,
    output logic [1:0]               trace_priv,
    output logic [SEQ_W-1:0]         trace_seq,
    output logic [DROP_W-1:0]        trace_drops,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    // Same layout as trace_entry_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INSN_W-1:0] insn;
        logic [1:0]        priv;
        logic [SEQ_W-1:0]  seq;
        logic [DROP_W-1:0] drops;
    } entry_t;

    logic [SEQ_W-1:0]  seq_r;
    logic [DROP_W-1:0] drop_r;
    logic              capture;
    logic              accept;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    entry_t            wr_entry;
    entry_t            rd_entry;

    assign capture     = retire_valid & enable & ~flush;
    assign accept      = capture & ~fifo_full;
    assign drop        = capture & fifo_full;
    assign trace_valid = ~fifo_empty;

    always_comb begin
        wr_entry.pc    = retire_pc;
        wr_entry.insn  = retire_insn;
        wr_entry.priv  = retire_priv;
        wr_entry.seq   = seq_r;
        wr_entry.drops = drop_r;
    end

    rocket_trace_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear   (flush),
        .push    (accept),
        .pop     (trace_ready),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (level)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            seq_r    <= '0;
            drop_r   <= '0;
            overflow <= 1'b0;
        end else begin
            if (capture) seq_r <= seq_r + 1'b1;
            if (flush) begin
                drop_r   <= '0;
                overflow <= 1'b0;
            end else if (accept) begin
                drop_r <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_r != '1) drop_r <= drop_r + 1'b1;
            end
        end
    end

    assign trace_pc    = rd_entry.pc;
    assign trace_insn  = rd_entry.insn;
    assign trace_priv  = rd_entry.priv;
    assign trace_seq   = rd_entry.seq;
    assign trace_drops = rd_entry.drops;

endmodule

// File: tb/tb_rocket_retire_trace_buf.sv
// Directed bench for rocket_retire_trace_buf with hand-computed expectations.
module tb_rocket_retire_trace_buf;
    import rocket_trace_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        flush;
    logic        retire_valid;
    logic [39:0] retire_pc;
    logic [31:0] retire_insn;
    logic [1:0]  retire_priv;
    logic        trace_valid;
    logic        trace_ready;
    logic [39:0] trace_pc;
    logic [31:0] trace_insn;
    logic [1:0]  trace_priv;
    logic [31:0] trace_seq;
    logic [15:0] trace_drops;
    logic        overflow;
    logic [4:0]  level;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    rocket_retire_trace_buf #(
        .DEPTH (16), .PC_W (40), .INSN_W (32), .SEQ_W (32), .DROP_W (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .flush        (flush),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_insn  (retire_insn),
        .retire_priv  (retire_priv),
        .trace_valid  (trace_valid),
        .trace_ready  (trace_ready),
        .trace_pc     (trace_pc),
        .trace_insn   (trace_insn),
        .trace_priv   (trace_priv),
        .trace_seq    (trace_seq),
        .trace_drops  (trace_drops),
        .overflow     (overflow),
        .level        (level)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] insn_of(input logic [39:0] pc);
        return {16'h0013, pc[15:0]};
    endfunction

    task automatic set_retire(input logic v, input logic [39:0] pc);
        retire_valid = v;
        retire_pc    = pc;
        retire_insn  = insn_of(pc);
        retire_priv  = PRIV_M;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_retire(1'b0, '0);
        trace_ready = 1'b0;
        flush = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Retire n instructions back to back, pc = base + 4*i.
    task automatic retire_n(input int n, input logic [39:0] base);
        for (int i = 0; i < n; i++) begin
            set_retire(1'b1, base + 40'(4 * i));
            tick();
        end
        set_retire(1'b0, '0);
    endtask

    // Pop n entries with ready high, checking each head's sequence number.
    task automatic drain_check(input string tag, input int n, input int first_seq);
        trace_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check(tag, {32'd0, trace_seq}, 64'(first_seq + i));
            tick();
        end
    endtask

    initial begin
        do_reset();
        check("rst_valid", trace_valid, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);

        // Three retires with the consumer always ready.
        trace_ready = 1'b1;
        set_retire(1'b1, 40'h1000);
        tick();
        check("t1_valid", trace_valid, 1);
        check("t1_pc0", trace_pc, 40'h1000);
        check("t1_insn0", trace_insn, 32'h0013_1000);
        check("t1_priv0", trace_priv, PRIV_M);
        check("t1_seq0", trace_seq, 0);
        set_retire(1'b1, 40'h1004);
        tick();
        check("t1_pc1", trace_pc, 40'h1004);
        check("t1_seq1", trace_seq, 1);
        set_retire(1'b1, 40'h1008);
        tick();
        check("t1_pc2", trace_pc, 40'h1008);
        check("t1_seq2", trace_seq, 2);
        check("t1_drops2", trace_drops, 0);
        check("t1_overflow", overflow, 0);
        set_retire(1'b0, '0);
        tick();
        check("t1_empty", trace_valid, 0);

        // 20 retires into a stalled 16-deep FIFO: 4 dropped.
        do_reset();
        retire_n(20, 40'h2000);
        check("t2_level", level, 16);
        check("t2_overflow", overflow, 1);
        check("t2_head_pc", trace_pc, 40'h2000);
        drain_check("t2_drain_seq", 16, 0);
        check("t2_drained", trace_valid, 0);
        set_retire(1'b1, 40'h3000);
        tick();
        set_retire(1'b0, '0);
        check("t2_next_pc", trace_pc, 40'h3000);
        check("t2_next_seq", trace_seq, 20);
        check("t2_next_drops", trace_drops, 4);
        check("t2_overflow_sticky", overflow, 1);
        tick();

        // Full FIFO with a retire and a pop in the same cycle.
        do_reset();
        retire_n(16, 40'h4000);
        check("t3_full_level", level, 16);
        check("t3_no_overflow", overflow, 0);
        trace_ready = 1'b1;
        set_retire(1'b1, 40'h5000);
        tick();
        set_retire(1'b0, '0);
        check("t3_level", level, 15);
        check("t3_overflow", overflow, 1);
        drain_check("t3_drain_seq", 15, 1);
        check("t3_drained", trace_valid, 0);
        set_retire(1'b1, 40'h5004);
        tick();
        set_retire(1'b0, '0);
        check("t3_next_seq", trace_seq, 17);
        check("t3_next_drops", trace_drops, 1);
        tick();

        // Enable low ignores retires; the next captured seq follows 17.
        enable = 1'b0;
        retire_n(5, 40'h6000);
        check("t4_level", level, 0);
        check("t4_valid", trace_valid, 0);
        enable = 1'b1;
        set_retire(1'b1, 40'h7000);
        tick();
        set_retire(1'b0, '0);
        check("t4_seq", trace_seq, 18);
        check("t4_drops", trace_drops, 0);
        check("t4_pc", trace_pc, 40'h7000);
        tick();

        // Flush with 6 queued and 3 pending drops, retire in the flush cycle.
        do_reset();
        trace_ready = 1'b0;
        retire_n(19, 40'h8000);
        drain_check("t5_drain_seq", 10, 0);
        trace_ready = 1'b0;
        check("t5_pre_level", level, 6);
        check("t5_pre_overflow", overflow, 1);
        flush = 1'b1;
        set_retire(1'b1, 40'h9000);
        tick();
        flush = 1'b0;
        set_retire(1'b0, '0);
        check("t5_level", level, 0);
        check("t5_overflow", overflow, 0);
        check("t5_valid", trace_valid, 0);
        set_retire(1'b1, 40'h9004);
        tick();
        set_retire(1'b0, '0);
        check("t5_seq", trace_seq, 19);
        check("t5_drops", trace_drops, 0);
        check("t5_pc", trace_pc, 40'h9004);

        // Reset mid-drain with 8 queued.
        do_reset();
        retire_n(8, 40'hA000);
        check("t6_pre_level", level, 8);
        trace_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_valid", trace_valid, 0);
        check("t6_level", level, 0);
        set_retire(1'b1, 40'hB000);
        tick();
        set_retire(1'b0, '0);
        check("t6_seq", trace_seq, 0);
        check("t6_drops", trace_drops, 0);
        check("t6_overflow", overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rocket_retire_trace_buf.md
# rocket_retire_trace_buf

Retired-instruction trace buffer that sits directly downstream of the per-core Rocket BFM in the SoC subsystem testbench. It captures one commit event per cycle from the core's retire port, tags each event with a sequence number and a count of preceding drops, and buffers the events in a synchronous FIFO. A valid/ready consumer, normally the trace transactor feeding the UVM scoreboard, drains the FIFO. The block never back-pressures the core: when the FIFO is full it drops events and accounts for them.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2
- PC_W, 40, retired PC width
- INSN_W, 32, instruction word width
- SEQ_W, 32, sequence-number width
- DROP_W, 16, saturating drop-count width

Ports:
- clock  in  1  sole clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  capture enable; when low, retires are ignored entirely
- flush  in  1  synchronous FIFO/drop-state clear
- retire_valid  in  1  one instruction retired this cycle
- retire_pc  in  PC_W  PC of the retired instruction
- retire_insn  in  INSN_W  retired instruction word
- retire_priv  in  2  privilege level at retire
- trace_valid  out  1  head entry available
- trace_ready  in  1  consumer accepts head entry
- trace_pc / trace_insn / trace_priv  out  PC_W / INSN_W / 2  head entry fields
- trace_seq  out  SEQ_W  sequence number of the head entry
- trace_drops  out  DROP_W  events dropped immediately before the head entry
- overflow  out  1  sticky; at least one drop since reset or flush
- level  out  $clog2(DEPTH)+1  current occupancy

## Operation
- A capture happens when `retire_valid & enable & ~flush`. Each capture increments `seq_r` (wraps modulo 2^SEQ_W).
- If the FIFO is not full, the captured event is written with `seq = seq_r` (pre-increment value) and `drops = drop_r`, and `drop_r` clears to 0.
- If the FIFO is full, the event is dropped. `drop_r` increments, saturating at 2^DROP_W−1, and `overflow` sets.
- Consumers therefore see sequence gaps equal to `trace_drops`, unless `drop_r` saturated.
- Full and empty are judged from the registered count only:
  - A push at full is dropped even if a pop occurs in the same cycle.
  - A pop at empty is ignored.
- Push and pop in the same cycle when neither full nor empty: `level` is unchanged.
- A pop occurs when `trace_valid & trace_ready`. The head advances and read/write pointers wrap modulo DEPTH.
- `flush` empties the FIFO and clears `drop_r` and `overflow`. `seq_r` is preserved. A retire in the flush cycle is discarded and does not increment `seq_r`.
- `enable` low: no capture and no `seq_r` change. Draining continues.
- `reset` forces every register to its reset value regardless of other inputs, including mid-drain. Entries in flight are lost.

## Timing
- Reset values: `trace_valid` 0, `overflow` 0, `level` 0, `seq_r` 0, `drop_r` 0. Data outputs are don't-care while `trace_valid` is 0; the bench must not check them then.
- Latency: a capture in cycle N into an empty FIFO gives `trace_valid` 1 in cycle N+1.
- Head fields are read combinationally from storage at the registered head pointer. They are stable while `trace_valid & ~trace_ready`.
- `trace_valid` stays high until a pop. The consumer may hold `trace_ready` high continuously.
- Throughput: one push and one pop per cycle sustained.
- `overflow` and `level` are registered and update in the cycle after the causing event.

## Structure
- `rocket_trace_pkg` holds:
  - `trace_entry_t` packed struct {pc, insn, priv, seq, drops}, using the package default widths
  - `PRIV_U/S/M` constants
- One sub-module, `rocket_trace_fifo`: a generic synchronous FIFO with parameters DEPTH and type/width T, and signals push/pop/full/empty/count. The top holds the seq/drop/overflow accounting and instantiates it once.

## Test plan
- After reset, 3 retires (pc 0x1000, 0x1004, 0x1008) with `trace_ready` held 1 → `trace_valid` rises one cycle after the first; seq 0,1,2; drops 0; `overflow` 0.
- With DEPTH=16 and `trace_ready` 0, 20 consecutive retires → `level`=16, `overflow`=1; then one more retire with ready 1 → drained entries seq 0..15, next accepted entry seq 20 with drops=4.
- Full FIFO, retire and pop in the same cycle → retire dropped and `drop_r` increments; `level` becomes 15.
- `enable`=0 during 5 retires, then `enable`=1 with one retire → that entry has seq equal to the prior last seq+1.
- Flush asserted with 6 entries queued and 3 pending drops, with a retire in the same cycle → next cycle `level` 0, `overflow` 0; next retire has drops 0 and seq unchanged by the flush-cycle retire.
- `reset` asserted mid-drain with 8 queued → next cycle `trace_valid` 0, `level` 0; first retire after reset has seq 0.
